pool2d_engine: RTL
==================

Name: pool2d_engine

Overview:
- Parametrised successor to the single-mode pooling layer block.
- Holds a multi-channel activation buffer written through an indexed write port.
- On a start pulse, scans every output window with configurable kernel and stride, in max or average mode.
- Streams one result per window out over a valid/ready handshake; sits between a conv/activation stage and the next layer's input memory.

Parameters:
- NAME, "POOL2D_DEFAULT_NAME", instance label.
- NUM_CHANNELS, 1, number of channels (entries) stored.
- INPUT_DIM, 5, square input side length.
- KERNEL_DIM, 3, square window side length.
- STRIDE, 1, window step in x and y.
- DATA_SIZE, 64, signed two's-complement element width.
- MODE, 0, 0 = max pooling; 1 = average pooling.
- OUTPUT_DIM, (INPUT_DIM-KERNEL_DIM)/STRIDE+1, derived output side length; not overridden.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_write  in  1  write strobe.
- in_data  in  DATA_SIZE  write data.
- in_ch  in  16  write channel index.
- in_y  in  16  write row index.
- in_x  in  16  write column index.
- start  in  1  begin pooling pass (single-cycle pulse).
- busy  out  1  high while a pass is in progress.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_data  out  DATA_SIZE  pooled value.
- out_ch  out  16  channel index of result.
- out_y  out  16  output row index of result.
- out_x  out  16  output column index of result.
- done  out  1  one-cycle pulse after the last result is accepted.

Behaviour:
- Reset: state IDLE; busy, out_valid and done = 0; out_data, out_ch, out_y, out_x = 0; counters cleared. Buffer contents are not cleared.
- Reset mid-pass: abandons the pass, returns to IDLE next cycle, and drops any pending result.
- Writes: accepted only in IDLE. Index out of range (ch ≥ NUM_CHANNELS, y or x ≥ INPUT_DIM) → write ignored. A write while busy is ignored.
- start: honoured only in IDLE; ignored while busy. A write and start in the same IDLE cycle: the write lands and the pass sees it.
- Buffer read: registered, 1-cycle latency.
- State IDLE: start → FETCH, counters (ch, oy, ox) = 0, busy = 1.
- State FETCH: one window element address per cycle, kx fastest then ky. Address = (ch, oy*STRIDE+ky, ox*STRIDE+kx). Lasts KERNEL_DIM² cycles, then → DRAIN.
- Accumulation: each returned element is folded into the accumulator. The first element of a window initialises it.
- State DRAIN: one cycle to absorb the last read, then → EMIT.
- State EMIT: out_valid = 1, with out_data/out_ch/out_y/out_x held stable until out_valid && out_ready.
- On handshake:
  - advance ox, then oy, then ch;
  - if this was the last window (ch=NUM_CHANNELS-1, oy=ox=OUTPUT_DIM-1) → DONE; else → FETCH.
- State DONE: done = 1 for one cycle, busy = 0, → IDLE.
- Latency: out_valid rises KERNEL_DIM²+1 edges after the edge entering FETCH (start edge or previous handshake edge).
- MODE 0: signed maximum.
- MODE 1:
  - Sum in an accumulator of DATA_SIZE+2*clog2(KERNEL_DIM)+1 bits, no overflow.
  - out_data = sum / KERNEL_DIM², signed, truncated toward zero, low DATA_SIZE bits.
- out_ready may be held high permanently: back-to-back windows then take KERNEL_DIM²+2 cycles each.
- out_ready asserted outside EMIT has no effect.

Test Plan:
- INPUT_DIM=4, K=2, STRIDE=2, MODE=0, 1 channel, write 1..16 row-major, start, out_ready=1 → out_data 6, 8, 14, 16 at (y,x) (0,0), (0,1), (1,0), (1,1); first out_valid 5 edges after start; done pulses once.
- Same data with MODE=1 → 3, 5, 11, 13.
- Negative window -5, -3, -8, -1 (K=2, INPUT_DIM=2) → MODE=0 gives -1; MODE=1 gives -4 (-17/4 truncated toward zero).
- Backpressure: drop out_ready for 3 cycles during EMIT → out_valid and all out_* fields stable; next window's fetch begins only after the handshake.
- Defaults (5,3,1), NUM_CHANNELS=2, ramp data → 18 results, ch-major then y then x; first result 10 edges after start; start pulse and in_write mid-pass ignored (results unchanged, buffer unchanged).
- Assert rst during FETCH of window 3 → next cycle busy=0, out_valid=0; a fresh start reproduces the full result sequence from window (0,0,0).

Source files
------------

// File: rtl/pool2d_engine.sv
// pool2d_engine
//   Multi-channel 2-D pooling engine. An activation buffer is filled through an
//   indexed write port while idle. A start pulse then scans every output window
//   (KERNEL_DIM x KERNEL_DIM, step STRIDE), either taking the signed maximum
//   (MODE 0) or the truncated average (MODE 1). Each window result is offered on
//   a valid/ready handshake.
//
//   Ports
//     clk, rst                 clock, synchronous active-high reset
//     in_write/in_data         buffer write strobe and data (idle only)
//     in_ch/in_y/in_x          buffer write address; out-of-range writes dropped
//     start                    begin a pass (honoured only when idle)
//     busy                     pass in progress
//     out_valid/out_ready      result handshake
//     out_data                 pooled value
//     out_ch/out_y/out_x       coordinates of the offered result
//     done                     one-cycle pulse after the last result is taken
module pool2d_engine #(
    parameter string NAME         = "POOL2D_DEFAULT_NAME",
    parameter int    NUM_CHANNELS = 1,
    parameter int    INPUT_DIM    = 5,
    parameter int    KERNEL_DIM   = 3,
    parameter int    STRIDE       = 1,
    parameter int    DATA_SIZE    = 64,
    parameter int    MODE         = 0,
    parameter int    OUTPUT_DIM   = (INPUT_DIM - KERNEL_DIM) / STRIDE + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_write,
    input  logic signed [DATA_SIZE-1:0] in_data,
    input  logic [15:0]                 in_ch,
    input  logic [15:0]                 in_y,
    input  logic [15:0]                 in_x,
    input  logic                        start,
    output logic                        busy,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [DATA_SIZE-1:0] out_data,
    output logic [15:0]                 out_ch,
    output logic [15:0]                 out_y,
    output logic [15:0]                 out_x,
    output logic                        done
);

    localparam int DEPTH = NUM_CHANNELS * INPUT_DIM * INPUT_DIM;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ACC_W = DATA_SIZE + 2 * $clog2(KERNEL_DIM) + 1;
    localparam int KK    = KERNEL_DIM * KERNEL_DIM;

    localparam logic signed [ACC_W-1:0] KK_S   = ACC_W'(KK);
    localparam logic [15:0]             K_LAST = 16'(KERNEL_DIM - 1);
    localparam logic [15:0]             O_LAST = 16'(OUTPUT_DIM - 1);
    localparam logic [15:0]             C_LAST = 16'(NUM_CHANNELS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_EMIT,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [15:0] ch_q, ch_d, oy_q, oy_d, ox_q, ox_d;
    logic [15:0] ky_q, ky_d, kx_q, kx_d;

    logic signed [DATA_SIZE-1:0] mem_q [DEPTH];
    logic signed [DATA_SIZE-1:0] rd_data_q;
    logic                        rd_vld_q;
    logic                        rd_first_q;
    logic signed [ACC_W-1:0]     acc_q, acc_d;
    logic signed [DATA_SIZE-1:0] out_data_q;

    logic          wr_ok;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_addr;

    // Fold one buffer element into the running window accumulator.
    function automatic logic signed [ACC_W-1:0] fold(
        input logic signed [ACC_W-1:0]     acc,
        input logic signed [DATA_SIZE-1:0] elem,
        input logic                        first
    );
        logic signed [ACC_W-1:0] ext;
        ext = ACC_W'(elem);
        if (first) begin
            return ext;
        end
        if (MODE == 0) begin
            return (ext > acc) ? ext : acc;
        end
        return acc + ext;
    endfunction

    // Turn the completed accumulator into the output word; signed division
    // truncates toward zero.
    function automatic logic signed [DATA_SIZE-1:0] finalize(
        input logic signed [ACC_W-1:0] acc
    );
        logic signed [ACC_W-1:0] quo;
        if (MODE == 0) begin
            return acc[DATA_SIZE-1:0];
        end
        quo = acc / KK_S;
        return quo[DATA_SIZE-1:0];
    endfunction

    assign wr_ok  = (32'(in_ch) < NUM_CHANNELS) && (32'(in_y) < INPUT_DIM) &&
                    (32'(in_x) < INPUT_DIM);
    assign wr_idx = AW'((32'(in_ch) * INPUT_DIM + 32'(in_y)) * INPUT_DIM + 32'(in_x));
    assign rd_addr = AW'((32'(ch_q) * INPUT_DIM + 32'(oy_q) * STRIDE + 32'(ky_q)) * INPUT_DIM
                         + 32'(ox_q) * STRIDE + 32'(kx_q));

    // Buffer write side: only while idle, so a pass always sees a frozen image.
    always_ff @(posedge clk) begin
        if (in_write && (state_q == S_IDLE) && wr_ok) begin
            mem_q[wr_idx] <= in_data;
        end
    end

    // Read stage: element returns one cycle after its address.
    always_ff @(posedge clk) begin
        rd_data_q <= mem_q[rd_addr];
        acc_q     <= acc_d;
    end

    always_comb begin
        acc_d = acc_q;
        if (rd_vld_q) begin
            acc_d = fold(acc_q, rd_data_q, rd_first_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ch_q       <= '0;
            oy_q       <= '0;
            ox_q       <= '0;
            ky_q       <= '0;
            kx_q       <= '0;
            rd_vld_q   <= 1'b0;
            rd_first_q <= 1'b0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            oy_q       <= oy_d;
            ox_q       <= ox_d;
            ky_q       <= ky_d;
            kx_q       <= kx_d;
            rd_vld_q   <= (state_q == S_FETCH);
            rd_first_q <= (state_q == S_FETCH) && (kx_q == '0) && (ky_q == '0);
            // DRAIN absorbs the final element, so acc_d is the finished window.
            if (state_q == S_DRAIN) begin
                out_data_q <= finalize(acc_d);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        oy_d    = oy_q;
        ox_d    = ox_q;
        ky_d    = ky_q;
        kx_d    = kx_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    ch_d    = '0;
                    oy_d    = '0;
                    ox_d    = '0;
                    ky_d    = '0;
                    kx_d    = '0;
                end
            end
            S_FETCH: begin
                if (kx_q == K_LAST) begin
                    kx_d = '0;
                    if (ky_q == K_LAST) begin
                        ky_d    = '0;
                        state_d = S_DRAIN;
                    end else begin
                        ky_d = ky_q + 16'd1;
                    end
                end else begin
                    kx_d = kx_q + 16'd1;
                end
            end
            S_DRAIN: begin
                state_d = S_EMIT;
            end
            S_EMIT: begin
                if (out_ready) begin
                    state_d = S_FETCH;
                    if (ox_q == O_LAST) begin
                        ox_d = '0;
                        if (oy_q == O_LAST) begin
                            oy_d = '0;
                            if (ch_q == C_LAST) begin
                                ch_d    = '0;
                                state_d = S_DONE;
                            end else begin
                                ch_d = ch_q + 16'd1;
                            end
                        end else begin
                            oy_d = oy_q + 16'd1;
                        end
                    end else begin
                        ox_d = ox_q + 16'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy      = (state_q == S_FETCH) || (state_q == S_DRAIN) || (state_q == S_EMIT);
    assign out_valid = (state_q == S_EMIT);
    assign done      = (state_q == S_DONE);
    assign out_data  = out_data_q;
    assign out_ch    = ch_q;
    assign out_y     = oy_q;
    assign out_x     = ox_q;

endmodule
